sen_func_streamer: RTL and testbench

Sequential reader for the sine-function lookup memory. On a start pulse it walks a programmed address window of the 24-bit sine table and streams each word out through a valid/ready handshake, one word per cycle when the consumer never stalls. It sits between the sine-function memory (combinational read: `rd` follows `a` in the same cycle) and the processor datapath or any downstream sample consumer.

---
 rtl/sen_func_streamer.sv | 124 ++++++++++++
 tb/tb_sen_func_streamer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sen_func_streamer.sv
// Sequential reader for the sine lookup memory: walks a clamped address window
// and streams words over valid/ready. Define SEN_FUNC_LOOP_EN to enable wrap/stop mode.
module sen_func_streamer #(
  parameter int WIDTH  = 24,
  parameter int AMOUNT = 302,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              loop,
  input  logic              stop,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_rd,
  output logic [WIDTH-1:0]  sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for start; window not latched
  // RUN   | loading words from the table into the sample register
  // DRAIN | final word loaded, waiting for it to be consumed
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(AMOUNT - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, first_r, last_r;
  logic [ADDR_W-1:0] first_c, last_c;
  logic              load, handshake, at_last, wrap, stop_run;

`ifdef SEN_FUNC_LOOP_EN
  logic loop_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      loop_r <= 1'b0;
    else if (state == IDLE && start)
      loop_r <= loop;
  end

  assign wrap     = loop_r;
  assign stop_run = stop;
`else
  logic unused_cfg;
  assign unused_cfg = loop ^ stop;
  assign wrap       = 1'b0;
  assign stop_run   = 1'b0;
`endif

  // Out-of-range indices saturate; an inverted window collapses to one word.
  always_comb begin
    first_c = (first_addr > MAX_ADDR) ? MAX_ADDR : first_addr;
    last_c  = (last_addr > MAX_ADDR) ? MAX_ADDR : last_addr;
    if (first_c > last_c)
      last_c = first_c;
  end

  assign load      = (state == RUN) && (!sample_valid || sample_ready);
  assign handshake = sample_valid && sample_ready;
  assign at_last   = (addr_q == last_r);
  assign mem_addr  = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN: begin
        if (stop_run)
          state_nxt = DRAIN;
        else if (load && at_last && !wrap)
          state_nxt = DRAIN;
      end
      DRAIN:   if (handshake) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      first_r      <= '0;
      last_r       <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= (state == DRAIN) && handshake;
      if (state == IDLE && start) begin
        first_r <= first_c;
        last_r  <= last_c;
        addr_q  <= first_c;
      end else if (load) begin
        if (!at_last)
          addr_q <= addr_q + 1'b1;
        else if (wrap)
          addr_q <= first_r;
      end
      if (load) begin
        sample       <= mem_rd;
        sample_valid <= 1'b1;
      end else if (handshake) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sen_func_streamer.sv
// Randomized and directed bench for sen_func_streamer; a window/queue model
// predicts the word stream, handshake count and done timing.
module tb_sen_func_streamer;
  localparam int WIDTH  = 24;
  localparam int AMOUNT = 302;
  localparam int ADDR_W = 9;
`ifdef SEN_FUNC_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, start, loop, stop, sample_ready;
  logic [ADDR_W-1:0] first_addr, last_addr, mem_addr;
  logic [WIDTH-1:0]  mem_rd, sample;
  logic              sample_valid, busy, done;
  int                checks = 0;
  int                errors = 0;

  always #5 clk = ~clk;

  assign mem_rd = WIDTH'(32'(mem_addr) * 3);

  sen_func_streamer #(.WIDTH(WIDTH), .AMOUNT(AMOUNT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .last_addr(last_addr),
    .loop(loop), .stop(stop), .mem_addr(mem_addr), .mem_rd(mem_rd), .sample(sample),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .busy(busy), .done(done)
  );

  function automatic int ram(input int i);
    return i * 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge; start is raised immediately so a call right after a
  // done cycle exercises start-in-done-cycle.
  task automatic run_pass(input int f, input int l, input int mode, input bit lp,
                          input int stop_after, input bit ign_start);
    int ff, ll, n, hs, cyc;
    int exp_q[$];
    logic [WIDTH-1:0] held;
    bit hold, last_hs, seen_done;
    ff = (f > AMOUNT - 1) ? AMOUNT - 1 : f;
    ll = (l > AMOUNT - 1) ? AMOUNT - 1 : l;
    if (ff > ll) ll = ff;
    if (LOOP_EN && lp && stop_after > 0)
      for (int k = 0; k <= stop_after; k++) exp_q.push_back(ram(ff + k % (ll - ff + 1)));
    else
      for (int i = ff; i <= ll; i++) exp_q.push_back(ram(i));
    n = exp_q.size();
    start = 1'b1; first_addr = ADDR_W'(f); last_addr = ADDR_W'(l); loop = lp;
    sample_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    check("mem_addr_first", 32'(mem_addr), ff);
    hs = 0; cyc = 0; hold = 0; last_hs = 0; seen_done = 0; held = '0;
    while (!seen_done && cyc < 600) begin
      if (cyc == 0) check("valid_lat0", 32'(sample_valid), 0);
      if (cyc == 1) check("valid_lat1", 32'(sample_valid), 1);
      if (ign_start && cyc == 2) begin
        start = 1'b1; first_addr = 0; last_addr = 200;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen_done = 1;
        check("done_timing", 32'(last_hs && exp_q.size() == 0), 1);
        check("busy_at_done", 32'(busy), 0);
      end else begin
        if (hold) check("stall_stable", 32'(sample), 32'(held));
        case (mode)
          0:       sample_ready = 1'b1;
          1:       sample_ready = (cyc % 3 == 1);
          default: sample_ready = 1'($urandom_range(0, 1));
        endcase
        last_hs = sample_valid && sample_ready;
        hold    = sample_valid && !sample_ready;
        held    = sample;
        if (last_hs) begin
          if (exp_q.size() == 0) check("word_count", hs + 1, n);
          else check("sample", 32'(sample), exp_q.pop_front());
          hs++;
          if (stop_after > 0 && hs == stop_after) stop = 1'b1;
        end
        cyc++;
        @(negedge clk);
      end
    end
    stop = 1'b0; start = 1'b0;
    check("pass_done", 32'(seen_done), 1);
    check("handshakes", hs, n);
  endtask

  initial begin
    int gap;
    bit any_done;
    rst = 1'b1; start = 1'b0; loop = 1'b0; stop = 1'b0; sample_ready = 1'b0;
    first_addr = '0; last_addr = '0;
    @(negedge clk);
    check("rst_sample", 32'(sample), 0);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_addr", 32'(mem_addr), 0);
    rst = 1'b0;
    @(negedge clk);

    run_pass(10, 13, 0, 0, 0, 0);
    run_pass(10, 13, 1, 0, 0, 1);
    run_pass(400, 500, 0, 0, 0, 0);
    run_pass(20, 5, 1, 0, 0, 0);

    @(negedge clk);
    start = 1'b1; first_addr = 10; last_addr = 13; loop = 1'b0; sample_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_sample", 32'(sample), 36);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_sample", 32'(sample), 0);
    check("mid_rst_valid", 32'(sample_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_addr", 32'(mem_addr), 0);
    #1 rst = 1'b0;
    any_done = 0;
    repeat (6) begin
      @(negedge clk);
      any_done |= done;
    end
    check("no_done_after_abort", 32'(any_done), 0);
    run_pass(0, 1, 0, 0, 0, 0);

    @(negedge clk);
    run_pass(300, 301, 0, 1, 5, 0);

    for (int t = 0; t < 10; t++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      run_pass($urandom_range(0, 320), $urandom_range(0, 320), 2, 0, 0, 0);
    end
    @(negedge clk);
    check("done_single_cycle", 32'(done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
